lif_neuron_param: RTL and testbench

Parametrised leaky integrate-and-fire neuron. It is the next-generation core behind the Tiny Tapeout top level.
- Adds over the fixed 8-bit neuron: configurable width, runtime threshold and leak, selectable reset mode, an absolute refractory period and a saturating spike counter.
- Sits directly under the top wrapper. `current` is driven from the dedicated inputs; `state`, `spike` and `spike_count` drive the outputs / bidirectionals.

---
 rtl/lif_neuron_param.sv | 97 +++++++++
 tb/tb_lif_neuron_param.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lif_neuron_param.sv
// rtl/lif_neuron_param.sv - parametrised leaky integrate-and-fire neuron with refractory period and spike counter
module lif_neuron_param #(
  parameter int WIDTH         = 8,
  parameter int REFRAC_CYCLES = 4,
  parameter int CNT_WIDTH     = 8,
  parameter int LS_WIDTH      = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic [WIDTH-1:0]     current,
  input  logic [WIDTH-1:0]     threshold,
  input  logic [LS_WIDTH-1:0]  leak_shift,
  input  logic                 reset_mode,
  input  logic                 count_clr,
  output logic [WIDTH-1:0]     state,
  output logic                 spike,
  output logic                 refractory,
  output logic [CNT_WIDTH-1:0] spike_count
);

  localparam int RC_W = (REFRAC_CYCLES > 0) ? $clog2(REFRAC_CYCLES + 1) : 1;
  localparam logic [RC_W-1:0]      RC_LOAD = RC_W'(REFRAC_CYCLES);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  typedef enum logic {INTEG, REFRAC} fsm_t;

  fsm_t                 fsm_q, fsm_d;
  logic [RC_W-1:0]      rc_q, rc_d;
  logic [WIDTH-1:0]     state_d;
  logic                 spike_d;
  logic [CNT_WIDTH-1:0] count_d;
  logic [WIDTH-1:0]     leak;
  logic [WIDTH:0]       sum;
  logic [WIDTH-1:0]     next_v;

  // leak never exceeds state, so the extra sum bit only ever carries overflow
  always_comb begin
    leak   = (leak_shift == '0) ? '0 : (state >> leak_shift);
    sum    = {1'b0, state} - {1'b0, leak} + {1'b0, current};
    next_v = sum[WIDTH] ? '1 : sum[WIDTH-1:0];
  end

  always_comb begin
    fsm_d   = fsm_q;
    rc_d    = rc_q;
    state_d = state;
    spike_d = 1'b0;
    if (en) begin
      case (fsm_q)
        INTEG: begin
          if (next_v >= threshold) begin
            spike_d = 1'b1;
            state_d = reset_mode ? (next_v - threshold) : '0;
            if (REFRAC_CYCLES > 0) begin
              fsm_d = REFRAC;
              rc_d  = RC_LOAD;
            end
          end else begin
            state_d = next_v;
          end
        end
        REFRAC: begin
          rc_d = rc_q - RC_W'(1);
          if (rc_q == RC_W'(1)) fsm_d = INTEG;
        end
        default: fsm_d = INTEG;
      endcase
    end
    // a clear coinciding with a spike still counts that spike
    if (count_clr)
      count_d = CNT_WIDTH'(spike_d);
    else if (spike_d && (spike_count != CNT_MAX))
      count_d = spike_count + CNT_WIDTH'(1);
    else
      count_d = spike_count;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q       <= INTEG;
      rc_q        <= '0;
      state       <= '0;
      spike       <= 1'b0;
      spike_count <= '0;
    end else begin
      fsm_q       <= fsm_d;
      rc_q        <= rc_d;
      state       <= state_d;
      spike       <= spike_d;
      spike_count <= count_d;
    end
  end

  assign refractory = (fsm_q == REFRAC);

endmodule

// File: tb/tb_lif_neuron_param.sv
// tb/tb_lif_neuron_param.sv - self-checking bench for lif_neuron_param (REFRAC 0 and 4 instances)
module tb_lif_neuron_param;

  logic       clk = 1'b0;
  logic       rst_n, en, reset_mode, count_clr;
  logic [7:0] current, threshold;
  logic [2:0] leak_shift;

  logic [7:0] st_o [2];
  logic       sp_o [2];
  logic       rf_o [2];
  logic [7:0] cn_o [2];

  int checks = 0;
  int errors = 0;

  // reference model: plain integer arithmetic, one entry per instance
  int m_st [2];
  int m_left [2];
  int m_sp [2];
  int m_cnt [2];

  always #5 clk = ~clk;

  lif_neuron_param #(.WIDTH(8), .REFRAC_CYCLES(0), .CNT_WIDTH(8), .LS_WIDTH(3)) dut0 (
    .clk(clk), .rst_n(rst_n), .en(en), .current(current), .threshold(threshold),
    .leak_shift(leak_shift), .reset_mode(reset_mode), .count_clr(count_clr),
    .state(st_o[0]), .spike(sp_o[0]), .refractory(rf_o[0]), .spike_count(cn_o[0]));

  lif_neuron_param #(.WIDTH(8), .REFRAC_CYCLES(4), .CNT_WIDTH(8), .LS_WIDTH(3)) dut4 (
    .clk(clk), .rst_n(rst_n), .en(en), .current(current), .threshold(threshold),
    .leak_shift(leak_shift), .reset_mode(reset_mode), .count_clr(count_clr),
    .state(st_o[1]), .spike(sp_o[1]), .refractory(rf_o[1]), .spike_count(cn_o[1]));

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_st[k] = 0; m_left[k] = 0; m_sp[k] = 0; m_cnt[k] = 0;
    end
  endtask

  task automatic model_edge();
    int lk, nx;
    for (int k = 0; k < 2; k++) begin
      m_sp[k] = 0;
      if (en) begin
        if (m_left[k] > 0) begin
          m_left[k]--;
        end else begin
          lk = (leak_shift == 0) ? 0 : (m_st[k] >> leak_shift);
          nx = m_st[k] - lk + int'(current);
          if (nx > 255) nx = 255;
          if (nx >= int'(threshold)) begin
            m_sp[k]   = 1;
            m_st[k]   = reset_mode ? nx - int'(threshold) : 0;
            m_left[k] = (k == 0) ? 0 : 4;
          end else begin
            m_st[k] = nx;
          end
        end
      end
      if (count_clr) m_cnt[k] = m_sp[k];
      else if (m_sp[k] == 1 && m_cnt[k] < 255) m_cnt[k]++;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic set_inputs(input int thr, input int ls, input int cur, input int mode);
    threshold = 8'(thr); leak_shift = 3'(ls); current = 8'(cur);
    reset_mode = mode[0]; en = 1'b1; count_clr = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    set_inputs(200, 1, 120, 0);
    #12;
    for (int k = 0; k < 2; k++) begin
      checks++;
      if ({st_o[k], sp_o[k], rf_o[k], cn_o[k]} !== 18'd0) begin
        errors++;
        $display("FAIL reset dut%0d: got st=%0d sp=%0b rf=%0b cnt=%0d want all zero",
                 k, st_o[k], sp_o[k], rf_o[k], cn_o[k]);
      end
    end
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_basic(input int mode);
    int e_st [6];
    e_st = (mode == 0) ? '{120, 180, 0, 120, 180, 0} : '{120, 180, 10, 125, 183, 12};
    set_inputs(200, 1, 120, mode);
    do_reset();
    for (int i = 0; i < 6; i++) begin
      tick();
      checks++;
      if (st_o[0] !== 8'(e_st[i]) || sp_o[0] !== ((i % 3) == 2)) begin
        errors++;
        $display("FAIL basic_mode%0d edge%0d: got st=%0d sp=%0b want st=%0d sp=%0b",
                 mode, i + 1, st_o[0], sp_o[0], e_st[i], (i % 3) == 2);
      end
      checks++;
      if ({st_o[0], sp_o[0], rf_o[0], cn_o[0]} !== {8'(m_st[0]), m_sp[0][0], m_left[0] > 0, 8'(m_cnt[0])}) begin
        errors++;
        $display("FAIL basic_model edge%0d: got st=%0d cnt=%0d want st=%0d cnt=%0d",
                 i + 1, st_o[0], cn_o[0], m_st[0], m_cnt[0]);
      end
    end
  endtask

  task automatic test_refractory();
    int e_st [10] = '{120, 180, 0, 0, 0, 0, 0, 120, 180, 0};
    int e_rf [10] = '{0, 0, 1, 1, 1, 1, 0, 0, 0, 1};
    set_inputs(200, 1, 120, 0);
    do_reset();
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++;
      if (st_o[1] !== 8'(e_st[i]) || rf_o[1] !== e_rf[i][0]) begin
        errors++;
        $display("FAIL refractory edge%0d: got st=%0d rf=%0b want st=%0d rf=%0d",
                 i + 1, st_o[1], rf_o[1], e_st[i], e_rf[i]);
      end
    end
  endtask

  task automatic test_saturation();
    set_inputs(255, 0, 200, 0);
    do_reset();
    tick();
    checks++;
    if (st_o[0] !== 8'd200 || sp_o[0] !== 1'b0) begin
      errors++;
      $display("FAIL sat_edge1: got st=%0d sp=%0b want st=200 sp=0", st_o[0], sp_o[0]);
    end
    tick();
    checks++;
    if (st_o[0] !== 8'd0 || sp_o[0] !== 1'b1) begin
      errors++;
      $display("FAIL sat_edge2: got st=%0d sp=%0b want st=0 sp=1", st_o[0], sp_o[0]);
    end
  endtask

  task automatic test_enable();
    int n_en;
    logic en_at_edge;
    set_inputs(200, 1, 120, 0);
    do_reset();
    tick();
    tick();
    en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (st_o[0] !== 8'd180 || sp_o[0] !== 1'b0) begin
        errors++;
        $display("FAIL enable_hold cyc%0d: got st=%0d sp=%0b want st=180 sp=0", i, st_o[0], sp_o[0]);
      end
    end
    en = 1'b1;
    tick();
    checks++;
    if (sp_o[0] !== 1'b1 || sp_o[1] !== 1'b1) begin
      errors++;
      $display("FAIL enable_resume: got sp0=%0b sp4=%0b want 1 1", sp_o[0], sp_o[1]);
    end
    n_en = 0;
    for (int i = 0; i < 20 && rf_o[1] === 1'b1; i++) begin
      en = ((i % 3) != 1);
      en_at_edge = en;
      tick();
      if (en_at_edge) n_en++;
      checks++;
      if ({st_o[1], sp_o[1], rf_o[1]} !== {8'(m_st[1]), m_sp[1][0], m_left[1] > 0}) begin
        errors++;
        $display("FAIL enable_refrac_model cyc%0d: got st=%0d rf=%0b want st=%0d rf=%0b",
                 i, st_o[1], rf_o[1], m_st[1], m_left[1] > 0);
      end
    end
    checks++;
    if (n_en != 4) begin
      errors++;
      $display("FAIL enable_refrac_len: got %0d enabled refractory edges want 4", n_en);
    end
    en = 1'b1;
  endtask

  task automatic test_counter();
    int found;
    set_inputs(0, $urandom_range(0, 7), $urandom_range(0, 255), 0);
    do_reset();
    for (int i = 0; i < 300; i++) begin
      tick();
      for (int k = 0; k < 2; k++) begin
        checks++;
        if ({st_o[k], sp_o[k], rf_o[k], cn_o[k]} !== {8'(m_st[k]), m_sp[k][0], m_left[k] > 0, 8'(m_cnt[k])}) begin
          errors++;
          $display("FAIL counter_model dut%0d cyc%0d: got st=%0d sp=%0b rf=%0b cnt=%0d want st=%0d sp=%0d rf=%0b cnt=%0d",
                   k, i, st_o[k], sp_o[k], rf_o[k], cn_o[k], m_st[k], m_sp[k], m_left[k] > 0, m_cnt[k]);
        end
      end
    end
    checks++;
    if (cn_o[0] !== 8'd255) begin
      errors++;
      $display("FAIL counter_saturate: got %0d want 255", cn_o[0]);
    end
    count_clr = 1'b1;
    tick();
    checks++;
    if (cn_o[0] !== 8'd1) begin
      errors++;
      $display("FAIL counter_clr_spike: got %0d want 1", cn_o[0]);
    end
    en = 1'b0;
    tick();
    checks++;
    if (cn_o[0] !== 8'd0 || cn_o[1] !== 8'd0) begin
      errors++;
      $display("FAIL counter_clr_idle: got %0d %0d want 0 0", cn_o[0], cn_o[1]);
    end
    count_clr = 1'b0;
    en = 1'b1;
    found = 0;
    for (int i = 0; i < 10 && found == 0; i++) begin
      tick();
      if (rf_o[1] === 1'b1 && cn_o[1] !== 8'd0) found = 1;
    end
    checks++;
    if (found == 0) begin
      errors++;
      $display("FAIL counter_reach_refrac: got no refractory state within 10 cycles want one");
    end
    #2;
    rst_n = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) begin
      checks++;
      if ({st_o[k], sp_o[k], rf_o[k], cn_o[k]} !== 18'd0) begin
        errors++;
        $display("FAIL async_reset dut%0d: got st=%0d sp=%0b rf=%0b cnt=%0d want all zero",
                 k, st_o[k], sp_o[k], rf_o[k], cn_o[k]);
      end
    end
    model_reset();
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_random();
    for (int i = 0; i < 1500; i++) begin
      threshold  = 8'($urandom_range(0, 255));
      current    = 8'($urandom_range(0, 90));
      leak_shift = 3'($urandom_range(0, 7));
      reset_mode = 1'($urandom_range(0, 1));
      en         = ($urandom_range(0, 9) != 0);
      count_clr  = ($urandom_range(0, 40) == 0);
      tick();
      for (int k = 0; k < 2; k++) begin
        checks++;
        if ({st_o[k], sp_o[k], rf_o[k], cn_o[k]} !== {8'(m_st[k]), m_sp[k][0], m_left[k] > 0, 8'(m_cnt[k])}) begin
          errors++;
          $display("FAIL random dut%0d cyc%0d: got st=%0d sp=%0b rf=%0b cnt=%0d want st=%0d sp=%0d rf=%0b cnt=%0d",
                   k, i, st_o[k], sp_o[k], rf_o[k], cn_o[k], m_st[k], m_sp[k], m_left[k] > 0, m_cnt[k]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic(0);
    test_basic(1);
    test_refractory();
    test_saturation();
    test_enable();
    test_counter();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
